// File: rtl/gray_counter_pkg.sv
// Shared definitions for the Gray-coded pointer counter.
// The next-state operation selected by the control priority mux.
package gray_counter_pkg;

  localparam int unsigned MinWidth = 2;
  localparam int unsigned MaxWidth = 32;

  typedef enum logic [1:0] {
    OpHold,
    OpClear,
    OpLoad,
    OpInc
  } op_e;

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary to reflected-binary Gray conversion.
module bin_to_gray #(
  parameter int unsigned DataWidth = 4
) (
  input  logic [DataWidth-1:0] bin_i,
  output logic [DataWidth-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_counter.sv
// Registered binary/Gray up-counter with clear, load, wrap pulse and a
// combinational look-ahead of the next Gray value.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int unsigned DataWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] load_val_i,
  input  logic                 en_i,
  output logic [DataWidth-1:0] bin_o,
  output logic [DataWidth-1:0] gray_o,
  output logic [DataWidth-1:0] gray_next_o,
  output logic                 wrap_o
);

  if (DataWidth < MinWidth || DataWidth > MaxWidth) begin : gen_bad_width
    $error("gray_counter: DataWidth out of range");
  end

  op_e                  op;
  logic [DataWidth-1:0] bin_q, bin_d;
  logic [DataWidth-1:0] gray_q, gray_d;
  logic                 wrap_q, wrap_d;
  logic [DataWidth:0]   bin_inc;

  // Reset is folded into the mux too, so gray_next_o reads zero under reset
  // and X on lower-priority controls cannot leak past an asserted rst_i.
  always_comb begin
    op = OpHold;
    if (rst_i || clear_i) begin
      op = OpClear;
    end else if (load_i) begin
      op = OpLoad;
    end else if (en_i) begin
      op = OpInc;
    end
  end

  assign bin_inc = {1'b0, bin_q} + {{DataWidth{1'b0}}, 1'b1};

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    unique case (op)
      OpClear: bin_d = '0;
      OpLoad:  bin_d = load_val_i;
      OpInc: begin
        bin_d  = bin_inc[DataWidth-1:0];
        wrap_d = bin_inc[DataWidth];
      end
      default: bin_d = bin_q;
    endcase
  end

  bin_to_gray #(
    .DataWidth(DataWidth)
  ) u_bin_to_gray (
    .bin_i (bin_d),
    .gray_o(gray_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_o       = bin_q;
  assign gray_o      = gray_q;
  assign gray_next_o = gray_d;
  assign wrap_o      = wrap_q;

endmodule
